// File: rtl/d_cmp_serial_pkg.sv
// Shared encodings for the serial D-stage branch comparator.
// Op codes, three-way result codes, FSM states and the taken decode.
package d_cmp_pkg;

    typedef enum logic [2:0] {
        CMP_OP_EQ  = 3'd0,
        CMP_OP_NE  = 3'd1,
        CMP_OP_LEZ = 3'd2,
        CMP_OP_GTZ = 3'd3,
        CMP_OP_LTZ = 3'd4,
        CMP_OP_GEZ = 3'd5,
        CMP_OP_LT  = 3'd6,
        CMP_OP_LTU = 3'd7
    } cmp_op_e;

    localparam logic [1:0] CMP_EQ = 2'b00;
    localparam logic [1:0] CMP_GT = 2'b01;
    localparam logic [1:0] CMP_LT = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic logic op_is_zero(input logic [2:0] op);
        return (op >= 3'd2) && (op <= 3'd5);
    endfunction

    function automatic logic op_is_signed(input logic [2:0] op);
        return (op >= 3'd2) && (op <= 3'd6);
    endfunction

    function automatic logic taken_of(input logic [2:0] op,
                                      input logic [1:0] c);
        logic t;
        t = 1'b0;
        case (cmp_op_e'(op))
            CMP_OP_EQ:  t = (c == CMP_EQ);
            CMP_OP_NE:  t = (c != CMP_EQ);
            CMP_OP_LEZ: t = (c != CMP_GT);
            CMP_OP_GTZ: t = (c == CMP_GT);
            CMP_OP_LTZ: t = (c == CMP_LT);
            CMP_OP_GEZ: t = (c != CMP_LT);
            CMP_OP_LT:  t = (c == CMP_LT);
            CMP_OP_LTU: t = (c == CMP_LT);
            default:    t = 1'b0;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/d_cmp_serial_cmp_slice.sv
// One SLICE-bit unsigned magnitude compare, shared by every slice
// of the serial comparator.
module cmp_slice #(
    parameter int SLICE = 8
) (
    input  logic [SLICE-1:0] i_a,
    input  logic [SLICE-1:0] i_b,
    output logic             o_eq,
    output logic             o_gt
);

    assign o_eq = (i_a == i_b);
    assign o_gt = (i_a >  i_b);

endmodule

// File: rtl/d_cmp_serial.sv
// Iterative MSB-first branch comparator, SLICE bits per cycle.
// D_CMP_SERIAL_EARLY_EXIT_EN: stop at first differing slice.
module d_cmp_serial
    import d_cmp_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SLICE = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [1:0]       cmp,
    output logic             taken,
    output logic             busy
);

    localparam int NSLICE = WIDTH / SLICE;
    localparam int IW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    if ((WIDTH % SLICE) != 0) begin : g_bad_cfg
        $error("WIDTH must be a multiple of SLICE");
    end

    state_e           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [2:0]       r_op;
    logic [IW-1:0]    r_idx;
    logic [1:0]       r_cmp;
    logic             r_taken;
    logic             r_found;
    logic [1:0]       r_res;

    state_e           w_state_nx;
    logic [WIDTH-1:0] w_a_nx;
    logic [WIDTH-1:0] w_b_nx;
    logic [2:0]       w_op_nx;
    logic [IW-1:0]    w_idx_nx;
    logic [1:0]       w_cmp_nx;
    logic             w_taken_nx;
    logic             w_found_nx;
    logic [1:0]       w_res_nx;

    logic             w_accept;
    logic [WIDTH-1:0] w_a_in;
    logic [WIDTH-1:0] w_b_in;
    logic [WIDTH-1:0] w_a_sh;
    logic [WIDTH-1:0] w_b_sh;
    logic             w_eq;
    logic             w_gt;
    logic [1:0]       w_res_sl;
    logic [1:0]       w_final;

    assign w_accept = in_valid && (r_state == IDLE) && !flush;

    // Flipping the sign bit turns a signed compare into an unsigned one.
    always_comb begin
        w_a_in = a;
        w_b_in = op_is_zero(op) ? '0 : b;
        if (op_is_signed(op)) begin
            w_a_in[WIDTH-1] = ~w_a_in[WIDTH-1];
            w_b_in[WIDTH-1] = ~w_b_in[WIDTH-1];
        end
    end

    assign w_a_sh = r_a >> (int'(r_idx) * SLICE);
    assign w_b_sh = r_b >> (int'(r_idx) * SLICE);

    cmp_slice #(
        .SLICE (SLICE)
    ) u_slice (
        .i_a  (w_a_sh[SLICE-1:0]),
        .i_b  (w_b_sh[SLICE-1:0]),
        .o_eq (w_eq),
        .o_gt (w_gt)
    );

    assign w_res_sl = w_gt ? CMP_GT : CMP_LT;

    always_comb begin
        w_state_nx = r_state;
        w_a_nx     = r_a;
        w_b_nx     = r_b;
        w_op_nx    = r_op;
        w_idx_nx   = r_idx;
        w_cmp_nx   = r_cmp;
        w_taken_nx = r_taken;
        w_found_nx = r_found;
        w_res_nx   = r_res;
        w_final    = r_found ? r_res : (w_eq ? CMP_EQ : w_res_sl);
        unique case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_nx = RUN;
                    w_a_nx     = w_a_in;
                    w_b_nx     = w_b_in;
                    w_op_nx    = op;
                    w_idx_nx   = IW'(NSLICE - 1);
                    w_found_nx = 1'b0;
                    w_res_nx   = CMP_EQ;
                end
            end
            RUN: begin
                if (flush) begin
                    w_state_nx = IDLE;
                end else begin
`ifdef D_CMP_SERIAL_EARLY_EXIT_EN
                    if (!w_eq || (r_idx == '0)) begin
                        w_state_nx = DONE;
                        w_cmp_nx   = w_eq ? CMP_EQ : w_res_sl;
                        w_taken_nx = taken_of(r_op, w_cmp_nx);
                    end else begin
                        w_idx_nx = r_idx - 1'b1;
                    end
`else
                    // Fixed latency: keep the first difference, ignore later ones.
                    if (r_idx == '0) begin
                        w_state_nx = DONE;
                        w_cmp_nx   = w_final;
                        w_taken_nx = taken_of(r_op, w_final);
                    end else begin
                        w_idx_nx = r_idx - 1'b1;
                        if (!r_found && !w_eq) begin
                            w_found_nx = 1'b1;
                            w_res_nx   = w_res_sl;
                        end
                    end
`endif
                end
            end
            DONE: begin
                if (flush || out_ready) begin
                    w_state_nx = IDLE;
                end
            end
            default: begin
                w_state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_op    <= '0;
            r_idx   <= '0;
            r_cmp   <= CMP_EQ;
            r_taken <= 1'b0;
            r_found <= 1'b0;
            r_res   <= CMP_EQ;
        end else begin
            r_state <= w_state_nx;
            r_a     <= w_a_nx;
            r_b     <= w_b_nx;
            r_op    <= w_op_nx;
            r_idx   <= w_idx_nx;
            r_cmp   <= w_cmp_nx;
            r_taken <= w_taken_nx;
            r_found <= w_found_nx;
            r_res   <= w_res_nx;
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign busy      = (r_state != IDLE);
    assign cmp       = r_cmp;
    assign taken     = r_taken;

endmodule

// File: tb/tb_d_cmp_serial.sv
// Directed bench for d_cmp_serial (WIDTH=32, SLICE=8).
// Expected latency follows D_CMP_SERIAL_EARLY_EXIT_EN.
module tb_d_cmp_serial;

`ifdef D_CMP_SERIAL_EARLY_EXIT_EN
    localparam int EL = 1;
`else
    localparam int EL = 4;
`endif

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  cmp;
    logic        taken;
    logic        busy;

    int n_chk = 0;
    int n_err = 0;

    d_cmp_serial #(
        .WIDTH (32),
        .SLICE (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .cmp       (cmp),
        .taken     (taken),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic [31:0] ia, input logic [31:0] ib,
                       input logic [2:0] iop, output int lat);
        a        = ia;
        b        = ib;
        op       = iop;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        lat      = 0;
        while (!out_valid && lat < 40) begin
            step();
            lat++;
        end
    endtask

    task automatic do_case(input string tag, input logic [31:0] ia,
                           input logic [31:0] ib, input logic [2:0] iop,
                           input int xl, input logic [1:0] xc,
                           input logic xt);
        int lat;
        req(ia, ib, iop, lat);
        check({tag, "_lat"}, 32'(lat), 32'(xl));
        check({tag, "_cmp"}, 32'(cmp), 32'(xc));
        check({tag, "_tkn"}, 32'(taken), 32'(xt));
        check({tag, "_rdy"}, 32'(in_ready), 32'd0);
        step();
        check({tag, "_drop"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        int lat;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        op        = '0;
        flush     = 1'b0;
        out_ready = 1'b1;
        step();
        step();
        check("rst_ov", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_rdy", 32'(in_ready), 32'd1);
        check("rst_cmp", 32'(cmp), 32'd0);
        check("rst_tkn", 32'(taken), 32'd0);
        rst_n = 1'b1;
        step();

        do_case("eq",    32'h12345678, 32'h12345678, 3'd0, 4,  2'b00, 1'b1);
        do_case("ltu_e", 32'h12345678, 32'h12345678, 3'd7, 4,  2'b00, 1'b0);
        do_case("lt",    32'hFFFFFFFF, 32'h00000001, 3'd6, EL, 2'b10, 1'b1);
        do_case("ltu",   32'hFFFFFFFF, 32'h00000001, 3'd7, EL, 2'b01, 1'b0);
        do_case("gez",   32'h80000000, 32'hFFFFFFFF, 3'd5, EL, 2'b10, 1'b0);
        do_case("lez",   32'h00000000, 32'hFFFFFFFF, 3'd2, 4,  2'b00, 1'b1);
        do_case("lt_mn", 32'h80000000, 32'h00000000, 3'd6, EL, 2'b10, 1'b1);
        do_case("ltu_m", 32'h80000000, 32'h00000000, 3'd7, EL, 2'b01, 1'b0);
        do_case("eq_top",32'hFF000000, 32'h00000000, 3'd0, EL, 2'b01, 1'b0);
        do_case("first", 32'h01FF0000, 32'h02000000, 3'd7, EL, 2'b10, 1'b1);
        do_case("ne",    32'h12345678, 32'h12345679, 3'd1, 4,  2'b10, 1'b1);
        do_case("ltz",   32'hFFFFFFFF, 32'h00000000, 3'd4, EL, 2'b10, 1'b1);
        do_case("gtz",   32'h00000005, 32'hFFFFFFFF, 3'd3, 4,  2'b01, 1'b1);

        // asynchronous reset in the middle of RUN
        a        = 32'h12345678;
        b        = 32'h12345678;
        op       = 3'd0;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        check("mid_busy", 32'(busy), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_ov", 32'(out_valid), 32'd0);
        check("mid_busy0", 32'(busy), 32'd0);
        check("mid_rdy", 32'(in_ready), 32'd1);
        check("mid_cmp", 32'(cmp), 32'd0);
        step();
        rst_n = 1'b1;
        step();

        // backpressure in DONE
        out_ready = 1'b0;
        req(32'hFFFFFFFF, 32'h00000001, 3'd6, lat);
        check("bp_lat", 32'(lat), 32'(EL));
        for (int i = 0; i < 5; i++) begin
            step();
            check("bp_ov", 32'(out_valid), 32'd1);
            check("bp_cmp", 32'(cmp), 32'd2);
            check("bp_tkn", 32'(taken), 32'd1);
            check("bp_rdy", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        step();
        check("bp_drop", 32'(out_valid), 32'd0);
        check("bp_rdy1", 32'(in_ready), 32'd1);
        do_case("bp_new", 32'h00000001, 32'h00000002, 3'd7, 4, 2'b10, 1'b1);

        // flush coinciding with completion, out_ready high
        a        = 32'h12345678;
        b        = 32'h12345678;
        op       = 3'd0;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        step();
        step();
        check("fl_pre_ov", 32'(out_valid), 32'd0);
        check("fl_pre_busy", 32'(busy), 32'd1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("fl_ov", 32'(out_valid), 32'd0);
        check("fl_busy", 32'(busy), 32'd0);
        check("fl_rdy", 32'(in_ready), 32'd1);

        // flush while holding in DONE
        out_ready = 1'b0;
        req(32'h00000003, 32'h00000001, 3'd7, lat);
        check("fld_ov", 32'(out_valid), 32'd1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        out_ready = 1'b1;
        check("fld_drop", 32'(out_valid), 32'd0);
        check("fld_busy", 32'(busy), 32'd0);

        // flush in IDLE blocks acceptance; idle with no request stays idle
        in_valid = 1'b1;
        flush    = 1'b1;
        step();
        in_valid = 1'b0;
        flush    = 1'b0;
        check("fli_busy", 32'(busy), 32'd0);
        step();
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_rdy", 32'(in_ready), 32'd1);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
